// File: rtl/score_bcd_if.sv
// Score-to-BCD handshake and result bundle.
//   master : drives start/bin_in, observes results (producer / testbench side)
//   slave  : converter side, receives start/bin_in, drives results
//   start    request conversion of bin_in
//   bin_in   binary score
//   bcd      packed BCD result, digit 0 in bits [3:0]
//   nz_mask  per-digit significance, bit 0 always set
//   busy     conversion in progress
//   done     one-cycle pulse when results update
//   overflow last converted value did not fit in DIGITS digits
interface score_bcd_if #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     nz_mask;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  bcd, nz_mask, busy, done, overflow
    );

    modport slave (
        input  start, bin_in,
        output bcd, nz_mask, busy, done, overflow
    );
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter for the score display.
// One shift-add-3 iteration per clock; a conversion takes WIDTH clocks from
// the edge that accepts start. Also produces a leading-zero mask so the
// display can blank insignificant digits.
// Ports:
//   clk    single clock
//   reset  asynchronous, active-high; clears all state, discards conversion
//   bus    score_bcd_if.slave (start, bin_in, bcd, nz_mask, busy, done, overflow)
// Optional feature macro: SCORE_BCD_AUTO_EN
//   Defined   : a change of bin_in versus the last accepted value also starts
//               a conversion while idle (OR'd with the start port).
//   Undefined : conversions start only from the start port.
//
// state    | meaning
// ST_IDLE  | waiting for start, outputs hold last result
// ST_SHIFT | running WIDTH shift-add-3 iterations
module score_bcd_converter #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic         clk,
    input  logic         reset,
    score_bcd_if.slave   bus
);
    localparam int          CNT_W  = $clog2(WIDTH + 1);
    localparam logic [63:0] MAXVAL = 64'(10 ** DIGITS - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     shift_reg;
    logic [4*DIGITS-1:0]  scratch, scratch_adj, scratch_sh, load_val;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf;
    logic [DIGITS-1:0]    nz_nxt;
    logic                 nz_acc;
    logic                 start_req, accept, step, finish;

`ifdef SCORE_BCD_AUTO_EN
    logic [WIDTH-1:0]     last_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       last_val <= '0;
        else if (accept) last_val <= bus.bin_in;
    end

    assign start_req = bus.start | (bus.bin_in != last_val);
`else
    assign start_req = bus.start;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: add-3 correction, shift, and the value/mask to load on finish.
    // The final iteration's shifted scratch is loaded directly so the result
    // appears on the same edge the counter expires.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scratch_sh = {scratch_adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
        load_val   = ovf ? {DIGITS{4'h9}} : scratch_sh;
        nz_acc     = 1'b0;
        nz_nxt     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_acc    = nz_acc | (load_val[4*i +: 4] != 4'h0);
            nz_nxt[i] = nz_acc;
        end
        nz_nxt[0] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            shift_reg    <= '0;
            scratch      <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            bus.bcd      <= '0;
            bus.nz_mask  <= DIGITS'(1);
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            bus.done <= finish;
            if (accept) begin
                shift_reg <= bus.bin_in;
                scratch   <= '0;
                cnt       <= CNT_W'(WIDTH);
                ovf       <= 64'(bus.bin_in) > MAXVAL;
                bus.busy  <= 1'b1;
            end else if (step) begin
                shift_reg <= shift_reg << 1;
                scratch   <= scratch_sh;
                cnt       <= cnt - CNT_W'(1);
                if (finish) begin
                    bus.bcd      <= load_val;
                    bus.nz_mask  <= nz_nxt;
                    bus.overflow <= ovf;
                    bus.busy     <= 1'b0;
                end
            end
        end
    end
endmodule
